// File: rtl/pio_pkg.sv
// Shared definitions for the PIO edge-interrupt block: register word addresses
// and the per-bit capture-source selection.
package pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_OUTSET   = 3'd1;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd2;
    localparam logic [2:0] ADDR_CAPTURE  = 3'd3;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd4;
    localparam logic [2:0] ADDR_RISE_EN  = 3'd5;
    localparam logic [2:0] ADDR_FALL_EN  = 3'd6;
    localparam logic [2:0] ADDR_RSVD     = 3'd7;

    // Encoding is {rise_en, fall_en} for one bit.
    typedef enum logic [1:0] {
        MODE_LEVEL = 2'b00,
        MODE_FALL  = 2'b01,
        MODE_RISE  = 2'b10,
        MODE_ANY   = 2'b11
    } edge_mode_e;

    function automatic logic edge_set(
        input logic rise_en,
        input logic fall_en,
        input logic rise,
        input logic fall,
        input logic level
    );
        logic       set_v;
        edge_mode_e mode_v;
        mode_v = edge_mode_e'({rise_en, fall_en});
        case (mode_v)
            MODE_RISE:  set_v = rise;
            MODE_FALL:  set_v = fall;
            MODE_ANY:   set_v = rise | fall;
            MODE_LEVEL: set_v = level;
            default:    set_v = level;
        endcase
        return set_v;
    endfunction

endpackage

// File: rtl/pio_sync.sv
// Multi-flop synchronizer for the asynchronous PIO inputs, with one extra
// delay stage so the consumer can detect edges on the synchronized value.
module pio_sync #(
    parameter int WIDTH       = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] async_in,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_d
);

    logic [WIDTH-1:0] stage_r [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d_r;

    // Synchronizer chain plus edge-detect delay flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= {WIDTH{1'b0}};
            end
            sync_d_r <= {WIDTH{1'b0}};
        end else begin
            stage_r[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
            sync_d_r <= stage_r[SYNC_STAGES-1];
        end
    end

    assign sync_in = stage_r[SYNC_STAGES-1];
    assign sync_d  = sync_d_r;

endmodule

// File: rtl/pio_edge_irq.sv
// Parallel I/O port with set/clear output access and per-bit edge or level
// interrupt capture, presented as an 8-word slave register bank.
module pio_edge_irq
    import pio_pkg::*;
#(
    parameter int               WIDTH         = 17,
    parameter int               SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0] RESET_OUT     = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] RESET_RISE_EN = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    logic             wr_s;
    logic [WIDTH-1:0] wd_s;
    logic             unused_wd_s;

    logic [WIDTH-1:0] data_out_r;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] capture_r;
    logic [WIDTH-1:0] rise_en_r;
    logic [WIDTH-1:0] fall_en_r;
    logic [31:0]      readdata_r;

    logic [WIDTH-1:0] sync_in_s;
    logic [WIDTH-1:0] sync_d_s;
    logic [WIDTH-1:0] rise_s;
    logic [WIDTH-1:0] fall_s;
    logic [WIDTH-1:0] set_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] capture_nxt_s;
    logic [31:0]      rd_s;

    assign wr_s        = chipselect & ~write_n;
    assign wd_s        = writedata[WIDTH-1:0];
    assign unused_wd_s = &{1'b0, writedata};

    pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (in_port),
        .sync_in  (sync_in_s),
        .sync_d   (sync_d_s)
    );

    assign rise_s = sync_in_s & ~sync_d_s;
    assign fall_s = ~sync_in_s & sync_d_s;

    for (genvar i = 0; i < WIDTH; i++) begin : g_set
        assign set_s[i] = edge_set(rise_en_r[i], fall_en_r[i],
                                   rise_s[i], fall_s[i], sync_in_s[i]);
    end

    // W1C clear vector from a CAPTURE write.
    always_comb begin
        clr_s = {WIDTH{1'b0}};
        if (wr_s && (address == ADDR_CAPTURE)) begin
            clr_s = wd_s;
        end else begin
            clr_s = {WIDTH{1'b0}};
        end
    end

    // A new event always wins over a clear landing in the same cycle.
    assign capture_nxt_s = (capture_r & ~clr_s) | set_s;

    // Sticky capture register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            capture_r <= {WIDTH{1'b0}};
        end else begin
            capture_r <= capture_nxt_s;
        end
    end

    // Writable control and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out_r <= RESET_OUT;
            mask_r     <= {WIDTH{1'b0}};
            rise_en_r  <= RESET_RISE_EN;
            fall_en_r  <= {WIDTH{1'b0}};
        end else if (wr_s) begin
            case (address)
                ADDR_DATA:     data_out_r <= wd_s;
                ADDR_OUTSET:   data_out_r <= data_out_r | wd_s;
                ADDR_IRQ_MASK: mask_r     <= wd_s;
                ADDR_OUTCLR:   data_out_r <= data_out_r & ~wd_s;
                ADDR_RISE_EN:  rise_en_r  <= wd_s;
                ADDR_FALL_EN:  fall_en_r  <= wd_s;
                default: begin
                end
            endcase
        end
    end

    // Read mux; upper bits above WIDTH always read as zero.
    always_comb begin
        rd_s = 32'd0;
        case (address)
            ADDR_DATA:     rd_s[WIDTH-1:0] = sync_in_s;
            ADDR_OUTSET:   rd_s[WIDTH-1:0] = data_out_r;
            ADDR_IRQ_MASK: rd_s[WIDTH-1:0] = mask_r;
            ADDR_CAPTURE:  rd_s[WIDTH-1:0] = capture_r;
            ADDR_OUTCLR:   rd_s[WIDTH-1:0] = data_out_r;
            ADDR_RISE_EN:  rd_s[WIDTH-1:0] = rise_en_r;
            ADDR_FALL_EN:  rd_s[WIDTH-1:0] = fall_en_r;
            ADDR_RSVD:     rd_s            = 32'd0;
            default:       rd_s            = 32'd0;
        endcase
    end

    // Registered read data, refreshed every cycle regardless of chipselect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata_r <= 32'd0;
        end else begin
            readdata_r <= rd_s;
        end
    end

    assign readdata = readdata_r;
    assign out_port = data_out_r;
    assign irq      = |(capture_r & mask_r);

endmodule

// File: tb/tb_pio_edge_irq.sv
// Directed self-checking bench for pio_edge_irq with default parameters.
module tb_pio_edge_irq;

    localparam int W = 17;

    logic          clk;
    logic          reset_n;
    logic [2:0]    address;
    logic          chipselect;
    logic          write_n;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic [W-1:0]  in_port;
    logic [W-1:0]  out_port;
    logic          irq;

    int n_cmp;
    int n_fail;

    pio_edge_irq dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        address = a;
        @(posedge clk);
        #1;
        d = readdata;
    endtask

    task automatic test_reset;
        logic [31:0] d;
        tick(3);
        n_cmp++; if (readdata !== 32'd0) begin $display("FAIL rst_readdata got %h want %h", readdata, 32'd0); n_fail++; end
        n_cmp++; if (out_port !== 17'd0) begin $display("FAIL rst_out_port got %h want %h", out_port, 17'd0); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL rst_irq got %b want 0", irq); n_fail++; end
        reset_n = 1'b1;
        tick(5);
        bus_read(3'd5, d);
        n_cmp++; if (d !== 32'h0001FFFF) begin $display("FAIL rst_rise_en got %h want %h", d, 32'h0001FFFF); n_fail++; end
        bus_read(3'd6, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL rst_fall_en got %h want %h", d, 32'd0); n_fail++; end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL rst_mask got %h want %h", d, 32'd0); n_fail++; end
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL rst_capture got %h want %h", d, 32'd0); n_fail++; end
    endtask

    task automatic test_rise;
        logic [31:0] d;
        bus_write(3'd2, 32'h00000001);
        address = 3'd3;
        in_port = 17'h00001;
        tick(2);
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL rise_irq_early got %b want 0", irq); n_fail++; end
        tick(1);
        n_cmp++; if (irq !== 1'b1) begin $display("FAIL rise_irq got %b want 1", irq); n_fail++; end
        tick(1);
        n_cmp++; if (readdata !== 32'h1) begin $display("FAIL rise_capture got %h want %h", readdata, 32'h1); n_fail++; end
        bus_write(3'd3, 32'h00000001);
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL rise_irq_clear got %b want 0", irq); n_fail++; end
    endtask

    task automatic test_w1c_race;
        logic [31:0] d;
        in_port = 17'h00000;
        tick(4);
        in_port = 17'h00003;
        tick(4);
        in_port = 17'h00002;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h3) begin $display("FAIL race_setup got %h want %h", d, 32'h3); n_fail++; end
        in_port = 17'h00003;
        tick(2);
        bus_write(3'd3, 32'h00000001);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h3) begin $display("FAIL race_set_wins got %h want %h", d, 32'h3); n_fail++; end
        bus_write(3'd3, 32'h00000001);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h2) begin $display("FAIL race_clear got %h want %h", d, 32'h2); n_fail++; end
        bus_write(3'd3, 32'h0001FFFF);
    endtask

    task automatic test_fall;
        logic [31:0] d;
        in_port = 17'h00000;
        tick(4);
        bus_write(3'd3, 32'h0001FFFF);
        bus_write(3'd5, 32'h00000000);
        bus_write(3'd6, 32'h00000004);
        in_port = 17'h00004;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL fall_ignores_rise got %h want %h", d, 32'h0); n_fail++; end
        in_port = 17'h00000;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h4) begin $display("FAIL fall_capture got %h want %h", d, 32'h4); n_fail++; end
        bus_write(3'd3, 32'h00000004);
        bus_write(3'd5, 32'h00000004);
        in_port = 17'h00004;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h4) begin $display("FAIL any_rise got %h want %h", d, 32'h4); n_fail++; end
        bus_write(3'd3, 32'h00000004);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL any_cleared got %h want %h", d, 32'h0); n_fail++; end
        in_port = 17'h00000;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h4) begin $display("FAIL any_fall got %h want %h", d, 32'h4); n_fail++; end
        bus_write(3'd3, 32'h00000004);
    endtask

    task automatic test_level;
        logic [31:0] d;
        bus_write(3'd5, 32'h00000000);
        bus_write(3'd6, 32'h00000000);
        in_port = 17'h00020;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h20) begin $display("FAIL level_capture got %h want %h", d, 32'h20); n_fail++; end
        bus_write(3'd3, 32'h00000020);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h20) begin $display("FAIL level_reassert got %h want %h", d, 32'h20); n_fail++; end
        in_port = 17'h00000;
        tick(4);
        bus_write(3'd3, 32'h00000020);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h0) begin $display("FAIL level_cleared got %h want %h", d, 32'h0); n_fail++; end
    endtask

    task automatic test_out;
        logic [31:0] d;
        bus_write(3'd0, 32'h000000F0);
        bus_write(3'd1, 32'h00000003);
        bus_write(3'd4, 32'h00000010);
        n_cmp++; if (out_port !== 17'h000E3) begin $display("FAIL out_setclr got %h want %h", out_port, 17'h000E3); n_fail++; end
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'h000000E3) begin $display("FAIL read_outset got %h want %h", d, 32'h000000E3); n_fail++; end
        bus_read(3'd4, d);
        n_cmp++; if (d !== 32'h000000E3) begin $display("FAIL read_outclr got %h want %h", d, 32'h000000E3); n_fail++; end
        bus_write(3'd7, 32'h00001234);
        n_cmp++; if (out_port !== 17'h000E3) begin $display("FAIL rsvd_write got %h want %h", out_port, 17'h000E3); n_fail++; end
        bus_read(3'd7, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL rsvd_read got %h want %h", d, 32'd0); n_fail++; end
        bus_write(3'd0, 32'hFFFFFFFF);
        bus_read(3'd1, d);
        n_cmp++; if (d !== 32'h0001FFFF) begin $display("FAIL wide_write got %h want %h", d, 32'h0001FFFF); n_fail++; end
        in_port = 17'h0A5A5;
        tick(4);
        bus_read(3'd0, d);
        n_cmp++; if (d !== 32'h0000A5A5) begin $display("FAIL read_sync_in got %h want %h", d, 32'h0000A5A5); n_fail++; end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        in_port = 17'h00000;
        tick(4);
        bus_write(3'd5, 32'h00000001);
        in_port = 17'h1FFFF;
        tick(4);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h0001FFFF) begin $display("FAIL mid_capture_all got %h want %h", d, 32'h0001FFFF); n_fail++; end
        bus_write(3'd2, 32'h0001FFFF);
        n_cmp++; if (irq !== 1'b1) begin $display("FAIL mid_irq_on got %b want 1", irq); n_fail++; end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL mid_irq_async got %b want 0", irq); n_fail++; end
        n_cmp++; if (out_port !== 17'h00000) begin $display("FAIL mid_out_port got %h want %h", out_port, 17'h00000); n_fail++; end
        n_cmp++; if (readdata !== 32'd0) begin $display("FAIL mid_readdata got %h want %h", readdata, 32'd0); n_fail++; end
        #1;
        reset_n = 1'b1;
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL mid_capture_dropped got %h want %h", d, 32'd0); n_fail++; end
        bus_read(3'd5, d);
        n_cmp++; if (d !== 32'h0001FFFF) begin $display("FAIL mid_rise_en got %h want %h", d, 32'h0001FFFF); n_fail++; end
        bus_read(3'd2, d);
        n_cmp++; if (d !== 32'd0) begin $display("FAIL mid_mask got %h want %h", d, 32'd0); n_fail++; end
        tick(3);
        bus_read(3'd3, d);
        n_cmp++; if (d !== 32'h0001FFFF) begin $display("FAIL mid_release_rise got %h want %h", d, 32'h0001FFFF); n_fail++; end
        n_cmp++; if (irq !== 1'b0) begin $display("FAIL mid_irq_masked got %b want 0", irq); n_fail++; end
    endtask

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'd0;
        in_port    = 17'd0;
        test_reset();
        test_rise();
        test_w1c_race();
        test_fall();
        test_level();
        test_out();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
